// File: rtl/alu_fwd_ctrl.sv
// alu_fwd_ctrl: load-use / RAW hazard detection and EX operand-forwarding control.
// Optional feature macro ALU_FWD_CTRL_FWD_EN: when defined, operands forward from MEM/WB; when undefined, dependents stall.
module alu_fwd_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_alusrc,
    input  logic [4:0]  id_rd,
    input  logic        id_regwrite,
    input  logic        id_memread,
    output logic        stall,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        ex_alusrc,
    output logic [15:0] stall_cnt
);

    typedef struct packed {
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } stage_t;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam int EX  = 0;
    localparam int MEM = 1;
    localparam int WB  = 2;

    stage_t      stage_reg [3];
    stage_t      ex_next;
    state_t      state_reg;
    state_t      state_next;
    logic        hit_a [3];
    logic        hit_b [3];
    logic        use_a;
    logic        use_b;
    logic        hazard;
    logic        stall_int;
    logic        accept;
    logic [1:0]  fwd_a_reg;
    logic [1:0]  fwd_a_next;
    logic [1:0]  fwd_b_reg;
    logic [1:0]  fwd_b_next;
    logic        ex_alusrc_reg;
    logic        ex_alusrc_next;
    logic [15:0] stall_cnt_reg;

    // Operand B comes from the immediate when id_alusrc is set, so rt is not a real source then.
    assign use_a = id_valid & id_use_rs;
    assign use_b = id_valid & id_use_rt & ~id_alusrc;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_match
            logic live;
            assign live      = stage_reg[gi].regwrite && (stage_reg[gi].rd != 5'd0);
            assign hit_a[gi] = live && use_a && (stage_reg[gi].rd == id_rs);
            assign hit_b[gi] = live && use_b && (stage_reg[gi].rd == id_rt);
        end
    endgenerate

`ifdef ALU_FWD_CTRL_FWD_EN
    // Only a load still in EX cannot be forwarded in time.
    assign hazard = stage_reg[EX].memread && (hit_a[EX] || hit_b[EX]);
`else
    assign hazard = hit_a[EX] || hit_a[MEM] || hit_a[WB] ||
                    hit_b[EX] || hit_b[MEM] || hit_b[WB];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     if (hazard)  state_next = STALL;
            STALL:   if (!hazard) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Stall follows the live hazard so it drops in the same cycle the producer moves on.
    always_comb begin
        stall_int = hazard;
    end

    assign accept = id_valid & ~stall_int;

    always_comb begin
        ex_next        = '0;
        fwd_a_next     = 2'b00;
        fwd_b_next     = 2'b00;
        ex_alusrc_next = 1'b0;
        if (accept) begin
            ex_next.rd       = id_rd;
            ex_next.regwrite = id_regwrite;
            ex_next.memread  = id_memread;
            ex_alusrc_next   = id_alusrc;
`ifdef ALU_FWD_CTRL_FWD_EN
            // Current EX producer will sit in MEM next cycle, current MEM producer in WB.
            fwd_a_next = hit_a[EX] ? 2'b10 : (hit_a[MEM] ? 2'b01 : 2'b00);
            fwd_b_next = hit_b[EX] ? 2'b10 : (hit_b[MEM] ? 2'b01 : 2'b00);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_reg[EX]  <= '0;
            stage_reg[MEM] <= '0;
            stage_reg[WB]  <= '0;
            fwd_a_reg      <= 2'b00;
            fwd_b_reg      <= 2'b00;
            ex_alusrc_reg  <= 1'b0;
            stall_cnt_reg  <= 16'h0000;
        end else begin
            stage_reg[WB]  <= stage_reg[MEM];
            stage_reg[MEM] <= stage_reg[EX];
            stage_reg[EX]  <= ex_next;
            fwd_a_reg      <= fwd_a_next;
            fwd_b_reg      <= fwd_b_next;
            ex_alusrc_reg  <= ex_alusrc_next;
            if (stall_int && (stall_cnt_reg != 16'hFFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
        end
    end

    assign stall     = stall_int;
    assign fwd_a     = fwd_a_reg;
    assign fwd_b     = fwd_b_reg;
    assign ex_alusrc = ex_alusrc_reg;
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_alu_fwd_ctrl.sv
// tb_alu_fwd_ctrl: directed and randomized check of alu_fwd_ctrl against a per-register
// last-writer scoreboard (build with or without ALU_FWD_CTRL_FWD_EN).
`timescale 1ns/1ps
module tb_alu_fwd_ctrl;
`ifdef ALU_FWD_CTRL_FWD_EN
    localparam bit FWD        = 1'b1;
    localparam int SAT_CYCLES = 2000;
`else
    localparam bit FWD        = 1'b0;
    localparam int SAT_CYCLES = 87500;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs = '0;
    logic [4:0]  id_rt = '0;
    logic        id_use_rs = 1'b0;
    logic        id_use_rt = 1'b0;
    logic        id_alusrc = 1'b0;
    logic [4:0]  id_rd = '0;
    logic        id_regwrite = 1'b0;
    logic        id_memread = 1'b0;
    logic        stall;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        ex_alusrc;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_fwd_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_alusrc(id_alusrc), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .stall(stall), .fwd_a(fwd_a),
        .fwd_b(fwd_b), .ex_alusrc(ex_alusrc), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Model: for every register, the cycle its most recent writer was accepted into EX.
    // A writer accepted k cycles ago is k stages down the pipe (1=EX, 2=MEM, 3=WB).
    longint     cyc;
    longint     last_wr [32];
    bit         last_ld [32];
    int         exp_cnt;
    logic [1:0] exp_fa;
    logic [1:0] exp_fb;
    bit         exp_as;
    bit         exp_stall;
    bit         b_used;

    function automatic int age(input logic [4:0] r);
        if (r == 5'd0 || last_wr[r] < 0) return 99;
        return int'(cyc - last_wr[r]);
    endfunction

    function automatic bit blocks(input logic [4:0] r);
        int d = age(r);
        if (FWD) return (d == 1) && last_ld[r];
        return (d >= 1) && (d <= 3);
    endfunction

    function automatic logic [1:0] src_sel(input logic [4:0] r);
        int d = age(r);
        if (!FWD) return 2'b00;
        if (d == 1) return 2'b10;
        if (d == 2) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        cyc     = 0;
        exp_cnt = 0;
        exp_fa  = 2'b00;
        exp_fb  = 2'b00;
        exp_as  = 1'b0;
        for (int i = 0; i < 32; i++) begin
            last_wr[i] = -1;
            last_ld[i] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_stall", stall, 0);
            chk("rst_fwd_a", fwd_a, 0);
            chk("rst_fwd_b", fwd_b, 0);
            chk("rst_ex_alusrc", ex_alusrc, 0);
            chk("rst_stall_cnt", stall_cnt, 0);
            model_reset();
        end else begin
            b_used    = id_use_rt && !id_alusrc;
            exp_stall = id_valid && ((id_use_rs && blocks(id_rs)) || (b_used && blocks(id_rt)));
            chk("stall", stall, exp_stall);
            chk("fwd_a", fwd_a, exp_fa);
            chk("fwd_b", fwd_b, exp_fb);
            chk("ex_alusrc", ex_alusrc, exp_as);
            chk("stall_cnt", stall_cnt, exp_cnt);
            if (exp_stall && exp_cnt != 65535) exp_cnt++;
            if (id_valid && !exp_stall) begin
                exp_fa = id_use_rs ? src_sel(id_rs) : 2'b00;
                exp_fb = b_used ? src_sel(id_rt) : 2'b00;
                exp_as = id_alusrc;
                if (id_regwrite && id_rd != 5'd0) begin
                    last_wr[id_rd] = cyc;
                    last_ld[id_rd] = id_memread;
                end
            end else begin
                exp_fa = 2'b00;
                exp_fb = 2'b00;
                exp_as = 1'b0;
            end
            cyc++;
        end
    end

    task automatic drive(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                         input bit as, input int rd, input bit rw, input bit mr);
        @(posedge clk);
        #1;
        id_valid    = v;
        id_rs       = 5'(rs);
        id_rt       = 5'(rt);
        id_use_rs   = urs;
        id_use_rt   = urt;
        id_alusrc   = as;
        id_rd       = 5'(rd);
        id_regwrite = rw;
        id_memread  = mr;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Counts stall cycles seen by the instruction just driven, bounded.
    task automatic wait_accept(output int n);
        n = 0;
        @(negedge clk);
        while (stall && n < 8) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        id_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int  n;
    bit  hold;

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #3;
        chk("lit_rst_stall_cnt", stall_cnt, 0);
        chk("lit_rst_fwd_a", fwd_a, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // add $3 ; add $4,$3,$5
        drive(1, 1, 2, 1, 1, 0, 3, 1, 0);
        wait_accept(n);
        chk("lit_producer_no_stall", n, 0);
        drive(1, 3, 5, 1, 1, 0, 4, 1, 0);
        wait_accept(n);
`ifdef ALU_FWD_CTRL_FWD_EN
        chk("lit_alu_dep_stalls", n, 0);
        nop();
        @(negedge clk);
        chk("lit_alu_dep_fwd_a", fwd_a, 2);
        chk("lit_alu_dep_cnt", stall_cnt, 0);
        // lw $3 ; add $4,$3,$3
        do_reset();
        drive(1, 1, 0, 1, 0, 1, 3, 1, 1);
        wait_accept(n);
        drive(1, 3, 3, 1, 1, 0, 4, 1, 0);
        wait_accept(n);
        chk("lit_load_use_stalls", n, 1);
        nop();
        @(negedge clk);
        chk("lit_load_use_fwd_a", fwd_a, 1);
        chk("lit_load_use_fwd_b", fwd_b, 1);
        chk("lit_load_use_cnt", stall_cnt, 1);
`else
        chk("lit_alu_dep_stalls", n, 3);
        nop();
        @(negedge clk);
        chk("lit_alu_dep_fwd_a", fwd_a, 0);
        chk("lit_alu_dep_cnt", stall_cnt, 3);
`endif

        // Reset asserted while a load-use stall is in progress
        drive(1, 1, 0, 1, 0, 1, 7, 1, 1);
        wait_accept(n);
        drive(1, 7, 0, 1, 0, 0, 8, 1, 0);
        @(negedge clk);
        chk("lit_midstall_stall", stall, 1);
        chk("lit_midstall_alusrc", ex_alusrc, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("lit_async_stall", stall, 0);
        chk("lit_async_alusrc", ex_alusrc, 0);
        chk("lit_async_cnt", stall_cnt, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("lit_release_accepts", stall, 0);

        // addi $2 reading rt=$2 with immediate operand B; then writes to $0
        do_reset();
        drive(1, 1, 0, 1, 0, 0, 2, 1, 0);
        wait_accept(n);
        drive(1, 1, 2, 1, 1, 1, 2, 1, 0);
        wait_accept(n);
        chk("lit_addi_stalls", n, 0);
        nop();
        @(negedge clk);
        chk("lit_addi_fwd_b", fwd_b, 0);
        chk("lit_addi_ex_alusrc", ex_alusrc, 1);
        drive(1, 1, 0, 1, 0, 1, 0, 1, 1);
        wait_accept(n);
        drive(1, 0, 0, 1, 1, 0, 5, 1, 0);
        wait_accept(n);
        chk("lit_r0_stalls", n, 0);
        nop();
        @(negedge clk);
        chk("lit_r0_fwd_a", fwd_a, 0);
        chk("lit_r0_fwd_b", fwd_b, 0);

        // Randomized traffic; ID is held while stalled
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            hold = stall;
            @(posedge clk);
            #1;
            if (!hold) begin
                id_valid    = ($urandom_range(0, 4) != 0);
                id_rs       = 5'($urandom_range(0, 7));
                id_rt       = 5'($urandom_range(0, 7));
                id_use_rs   = ($urandom_range(0, 3) != 0);
                id_use_rt   = ($urandom_range(0, 1) != 0);
                id_alusrc   = ($urandom_range(0, 2) == 0);
                id_rd       = 5'($urandom_range(0, 7));
                id_regwrite = ($urandom_range(0, 3) != 0);
                id_memread  = id_regwrite && ($urandom_range(0, 2) == 0);
            end
        end

        // Self-dependent chain keeps stalling until the counter saturates
        do_reset();
        drive(1, 9, 0, 1, 0, 0, 9, 1, FWD);
        repeat (SAT_CYCLES) @(negedge clk);
`ifndef ALU_FWD_CTRL_FWD_EN
        chk("lit_stall_cnt_sat", stall_cnt, 16'hFFFF);
`endif
        nop();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_fwd_ctrl.md
ALU_FWD_CTRL -- requirements
Module: alu_fwd_ctrl

Interface
REQ-001 The module SHALL have these ports (name, direction, width, meaning), clock and reset first:
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 id_valid  in  1  ID stage holds a valid instruction.
REQ-005 id_rs, id_rt  in  5 each  ID source register numbers.
REQ-006 id_use_rs, id_use_rt  in  1 each  instruction reads rs / rt as a register operand.
REQ-007 id_alusrc  in  1  ALU operand B is the sign-extended immediate, not rt.
REQ-008 id_rd  in  5  ID destination register, already resolved by decode.
REQ-009 id_regwrite, id_memread  in  1 each  instruction writes id_rd / is a load.
REQ-010 stall  out  1  hold PC and IF/ID; insert bubble into EX.
REQ-011 fwd_a, fwd_b  out  2 each  EX operand A/B source: 00 register file, 01 WB result, 10 MEM result; 11 never driven.
REQ-012 ex_alusrc  out  1  registered operand-B mux select for EX.
REQ-013 stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-014 Internal tracking: three stage records (EX, MEM, WB), each holding rd, regwrite, memread; records shift EX->MEM->WB every cycle.
REQ-015 On a cycle with stall=0 and id_valid=1, ID fields SHALL load into the EX record; otherwise the EX record SHALL load a bubble (regwrite=0, memread=0).
REQ-016 fwd_a/fwd_b/ex_alusrc SHALL be registered, valid in the cycle the instruction occupies EX (one cycle after ID acceptance); they SHALL be 00/00/0 for bubbles.
REQ-017 Hazard match SHALL require producer regwrite=1, producer rd != 0, and the consumer use bit set; register 0 never stalls or forwards.
REQ-018 Operand B SHALL ignore rt matches when id_alusrc=1 (fwd_b=00).
REQ-019 Forward priority: MEM producer (10) over WB producer (01) for the same register.
REQ-020 FSM states RUN and STALL. RUN->STALL when a hazard requiring stall is detected for the ID instruction; STALL->RUN when no such hazard remains; stall=1 exactly while the hazard condition holds (combinational on current records, no extra cycle).
REQ-021 While stall=1, ID inputs SHALL be held stable by upstream; the block SHALL not latch them.
REQ-022 stall_cnt SHALL increment by 1 each cycle stall=1 and hold at 16'hFFFF.
REQ-023 Back-to-back dependent instructions, and a producer in both MEM and WB, SHALL resolve per REQ-019 with no stall unless REQ-020 applies.

Reset
REQ-024 rst_n low SHALL asynchronously clear all stage records to bubbles, FSM to RUN, stall=0, fwd_a=fwd_b=00, ex_alusrc=0, stall_cnt=0.
REQ-025 Reset asserted mid-stall SHALL abandon the stall; first cycle after release accepts ID normally.

Configuration
REQ-026 Macro ALU_FWD_CTRL_FWD_EN defined: forwarding active; stall only for a load in EX matching an ID source (exactly 1 stall cycle).
REQ-027 ALU_FWD_CTRL_FWD_EN undefined: fwd_a/fwd_b SHALL be constant 00; stall SHALL assert while any matching producer is in EX, MEM or WB (up to 3 cycles).

Verification
REQ-028 With FWD_EN: add $3 then add $4,$3,$5 -> no stall; fwd_a=10 in consumer EX cycle.
REQ-029 With FWD_EN: lw $3 then add $4,$3,$3 -> stall=1 for exactly 1 cycle, then fwd_a=fwd_b=01; stall_cnt=1.
REQ-030 addi $2 writing $2 while rt=$2 with id_alusrc=1 -> fwd_b=00, ex_alusrc=1; writes to $0 -> no stall, fwd 00.
REQ-031 Without FWD_EN: add $3 then dependent add -> stall=1 for 3 cycles, fwd 00; stall_cnt=3.
REQ-032 Assert rst_n low during a stall -> all outputs zero immediately; 70000 forced stall cycles -> stall_cnt=16'hFFFF.
